// File: rtl/rv32imf_wb_pkg.sv
// Shared types for the long-latency write-back stage: source identifiers and the
// per-source result request bundle.
package rv32imf_wb_pkg;

    localparam int NUM_WB_SRC    = 3;
    localparam int WB_ADDR_WIDTH = 6;
    localparam int WB_DATA_WIDTH = 32;

    // Enum order is also the round-robin order and the arbiter request/grant bit index.
    typedef enum logic [1:0] {
        WB_LSU = 2'd0,
        WB_MD  = 2'd1,
        WB_FPU = 2'd2
    } wb_src_e;

    typedef struct packed {
        logic                     valid;
        logic [WB_ADDR_WIDTH-1:0] waddr;
        logic [WB_DATA_WIDTH-1:0] wdata;
    } wb_req_t;

endpackage

// File: rtl/rv32imf_rr_arbiter.sv
// N-way round-robin arbiter: the search starts at the pointer, and the pointer moves
// to the entry after the winner whenever a grant is given.
module rv32imf_rr_arbiter #(
    parameter int N = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] i_req,
    output logic [N-1:0] o_gnt
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_idx;
    logic [PW-1:0] w_winner;
    logic          w_any;

    always_comb begin
        o_gnt    = '0;
        w_any    = 1'b0;
        w_winner = r_ptr;
        w_idx    = '0;
        for (int off = 0; off < N; off++) begin
            w_idx = PW'((int'(r_ptr) + off) % N);
            if (!w_any && i_req[w_idx]) begin
                w_any        = 1'b1;
                w_winner     = w_idx;
                o_gnt[w_idx] = 1'b1;
            end
        end
    end

    // Index 0 is the first source searched after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_any) begin
            r_ptr <= (w_winner == PW'(N - 1)) ? '0 : w_winner + PW'(1);
        end
    end

endmodule

// File: rtl/rv32imf_wb_arbiter.sv
// Long-latency write-back: arbitrates LSU / mult-div / FPU results onto register-file
// write port B and tracks pending writes for RAW/WAW hazard detection at issue.
module rv32imf_wb_arbiter
    import rv32imf_wb_pkg::*;
#(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int FPU        = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  issue_valid_i,
    input  logic [ADDR_WIDTH-1:0] issue_waddr_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [ADDR_WIDTH-1:0] lsu_waddr_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    input  logic                  md_valid_i,
    output logic                  md_ready_o,
    input  logic [ADDR_WIDTH-1:0] md_waddr_i,
    input  logic [DATA_WIDTH-1:0] md_wdata_i,
    input  logic                  fpu_valid_i,
    output logic                  fpu_ready_o,
    input  logic [ADDR_WIDTH-1:0] fpu_waddr_i,
    input  logic [DATA_WIDTH-1:0] fpu_wdata_i,
    output logic [ADDR_WIDTH-1:0] waddr_b_o,
    output logic [DATA_WIDTH-1:0] wdata_b_o,
    output logic                  we_b_o,
    input  logic [ADDR_WIDTH-1:0] raddr_a_i,
    input  logic [ADDR_WIDTH-1:0] raddr_b_i,
    input  logic [ADDR_WIDTH-1:0] raddr_c_i,
    output logic                  busy_a_o,
    output logic                  busy_b_o,
    output logic                  busy_c_o,
    output logic                  waw_busy_o
);

    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    wb_req_t               w_req [NUM_WB_SRC];
    logic [NUM_WB_SRC-1:0] w_reqv;
    logic [NUM_WB_SRC-1:0] w_gnt;
    logic                  w_gnt_any;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;
    logic                  w_set;

    logic [ADDR_WIDTH-1:0] r_waddr_b;
    logic [DATA_WIDTH-1:0] r_wdata_b;
    logic                  r_we_b;
    logic [NUM_REGS-1:0]   r_sb;

    // Without an FPU its request is forced low, so it can never win or see ready.
    always_comb begin
        w_req[WB_LSU].valid = lsu_valid_i;
        w_req[WB_LSU].waddr = WB_ADDR_WIDTH'(lsu_waddr_i);
        w_req[WB_LSU].wdata = WB_DATA_WIDTH'(lsu_wdata_i);
        w_req[WB_MD].valid  = md_valid_i;
        w_req[WB_MD].waddr  = WB_ADDR_WIDTH'(md_waddr_i);
        w_req[WB_MD].wdata  = WB_DATA_WIDTH'(md_wdata_i);
        w_req[WB_FPU].valid = (FPU != 0) && fpu_valid_i;
        w_req[WB_FPU].waddr = WB_ADDR_WIDTH'(fpu_waddr_i);
        w_req[WB_FPU].wdata = WB_DATA_WIDTH'(fpu_wdata_i);
    end

    assign w_reqv = {w_req[WB_FPU].valid, w_req[WB_MD].valid, w_req[WB_LSU].valid};

    rv32imf_rr_arbiter #(
        .N (NUM_WB_SRC)
    ) u_rr_arbiter (
        .clk   (clk),
        .rst_n (rst_n),
        .i_req (w_reqv),
        .o_gnt (w_gnt)
    );

    assign lsu_ready_o = w_gnt[WB_LSU];
    assign md_ready_o  = w_gnt[WB_MD];
    assign fpu_ready_o = w_gnt[WB_FPU];
    assign w_gnt_any   = |w_gnt;

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int s = 0; s < NUM_WB_SRC; s++) begin
            if (w_gnt[s]) begin
                w_sel_addr = ADDR_WIDTH'(w_req[s].waddr);
                w_sel_data = DATA_WIDTH'(w_req[s].wdata);
            end
        end
    end

    // Results to x0 are consumed but never produce a write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we_b    <= 1'b0;
            r_waddr_b <= '0;
            r_wdata_b <= '0;
        end else begin
            r_we_b <= w_gnt_any && (w_sel_addr != '0);
            if (w_gnt_any) begin
                r_waddr_b <= w_sel_addr;
                r_wdata_b <= w_sel_data;
            end
        end
    end

    assign waddr_b_o = r_waddr_b;
    assign wdata_b_o = r_wdata_b;
    assign we_b_o    = r_we_b;

    assign w_set = issue_valid_i && (issue_waddr_i != '0) &&
                   ((FPU != 0) || !issue_waddr_i[ADDR_WIDTH-1]);

    // The set is written last so a new issue wins over a retiring write to the same register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sb <= '0;
        end else begin
            if (r_we_b) begin
                r_sb[r_waddr_b] <= 1'b0;
            end
            if (w_set) begin
                r_sb[issue_waddr_i] <= 1'b1;
            end
        end
    end

    assign busy_a_o   = r_sb[raddr_a_i];
    assign busy_b_o   = r_sb[raddr_b_i];
    assign busy_c_o   = r_sb[raddr_c_i];
    assign waw_busy_o = r_sb[issue_waddr_i];

    // Issuing over a pending write is only legal when that write retires on this edge.
    a_no_waw_issue: assert property (@(posedge clk) disable iff (!rst_n)
        issue_valid_i |-> (!waw_busy_o || (r_we_b && (r_waddr_b == issue_waddr_i))));

endmodule

// File: tb/tb_rv32imf_wb_arbiter.sv
// Self-checking bench for rv32imf_wb_arbiter (FPU enabled): directed scenarios plus a
// randomized phase, compared every cycle against a behavioural pending-write model.
module tb_rv32imf_wb_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          issueValid;
    logic [AW-1:0] issueWaddr;
    logic          lsuValid, mdValid, fpuValid;
    logic [AW-1:0] lsuWaddr, mdWaddr, fpuWaddr;
    logic [DW-1:0] lsuWdata, mdWdata, fpuWdata;
    logic          lsuReady, mdReady, fpuReady;
    logic [AW-1:0] waddrB;
    logic [DW-1:0] wdataB;
    logic          weB;
    logic [AW-1:0] raddrA, raddrB, raddrC;
    logic          busyA, busyB, busyC, wawBusy;

    rv32imf_wb_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .FPU        (1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .issue_valid_i (issueValid),
        .issue_waddr_i (issueWaddr),
        .lsu_valid_i   (lsuValid),
        .lsu_ready_o   (lsuReady),
        .lsu_waddr_i   (lsuWaddr),
        .lsu_wdata_i   (lsuWdata),
        .md_valid_i    (mdValid),
        .md_ready_o    (mdReady),
        .md_waddr_i    (mdWaddr),
        .md_wdata_i    (mdWdata),
        .fpu_valid_i   (fpuValid),
        .fpu_ready_o   (fpuReady),
        .fpu_waddr_i   (fpuWaddr),
        .fpu_wdata_i   (fpuWdata),
        .waddr_b_o     (waddrB),
        .wdata_b_o     (wdataB),
        .we_b_o        (weB),
        .raddr_a_i     (raddrA),
        .raddr_b_i     (raddrB),
        .raddr_c_i     (raddrC),
        .busy_a_o      (busyA),
        .busy_b_o      (busyB),
        .busy_c_o      (busyC),
        .waw_busy_o    (wawBusy)
    );

    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    // Behavioural model: whose turn it is, the pending write and a bit per pending register.
    int            mPtr;
    bit            mWe;
    logic [AW-1:0] mAddr;
    logic [DW-1:0] mData;
    bit [63:0]     mPend;
    bit [2:0]      mLastGnt;
    int            mG;
    int            cG;

    function automatic int expGrant(input bit [2:0] v, input int ptr);
        for (int k = 0; k < 3; k++) begin
            int s = (ptr + k) % 3;
            if (v[s]) return s;
        end
        return -1;
    endfunction

    function automatic logic [AW-1:0] srcAddr(input int s);
        return (s == 0) ? lsuWaddr : (s == 1) ? mdWaddr : fpuWaddr;
    endfunction

    function automatic logic [DW-1:0] srcData(input int s);
        return (s == 0) ? lsuWdata : (s == 1) ? mdWdata : fpuWdata;
    endfunction

    function automatic logic [AW-1:0] randAddr();
        int a = $urandom_range(0, 15);
        return (a >= 8) ? AW'(32 + a - 8) : AW'(a);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(
        input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld,
        input logic mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
        input logic fv, input logic [AW-1:0] fa, input logic [DW-1:0] fd,
        input logic iv, input logic [AW-1:0] ia);
        lsuValid = lv; lsuWaddr = la; lsuWdata = ld;
        mdValid  = mv; mdWaddr  = ma; mdWdata  = md;
        fpuValid = fv; fpuWaddr = fa; fpuWdata = fd;
        issueValid = iv; issueWaddr = ia;
    endtask

    task automatic idle(input logic [AW-1:0] ia);
        applyStimulus(0, '0, '0, 0, '0, '0, 0, '0, '0, 0, ia);
    endtask

    // Model advances on each edge from the stable inputs; reset clears it asynchronously.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mPtr = 0; mWe = 0; mAddr = '0; mData = '0; mPend = '0; mLastGnt = '0;
        end else begin
            mG = expGrant({fpuValid, mdValid, lsuValid}, mPtr);
            if (mWe) mPend[mAddr] = 1'b0;
            if (issueValid && issueWaddr != '0) mPend[issueWaddr] = 1'b1;
            mLastGnt = '0;
            mWe = 1'b0;
            if (mG >= 0) begin
                mLastGnt[mG] = 1'b1;
                mAddr = srcAddr(mG);
                mData = srcData(mG);
                mWe   = (mAddr != '0);
                mPtr  = (mG + 1) % 3;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        cG = expGrant({fpuValid, mdValid, lsuValid}, mPtr);
        checkOutput("lsu_ready", 32'(lsuReady), 32'(cG == 0));
        checkOutput("md_ready",  32'(mdReady),  32'(cG == 1));
        checkOutput("fpu_ready", 32'(fpuReady), 32'(cG == 2));
        checkOutput("we_b",      32'(weB),      32'(mWe));
        checkOutput("waddr_b",   32'(waddrB),   32'(mAddr));
        checkOutput("wdata_b",   wdataB,        mData);
        checkOutput("busy_a",    32'(busyA),    32'(mPend[raddrA]));
        checkOutput("busy_b",    32'(busyB),    32'(mPend[raddrB]));
        checkOutput("busy_c",    32'(busyC),    32'(mPend[raddrC]));
        checkOutput("waw_busy",  32'(wawBusy),  32'(mPend[issueWaddr]));
    end

    bit [2:0]      rotExp [6] = '{3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};
    int            rotCnt [3];
    bit [2:0]      curV;
    logic [AW-1:0] curA [3];
    logic [DW-1:0] curD [3];
    logic          rIv;
    logic [AW-1:0] rIa;
    logic [AW-1:0] busyRegs [4] = '{6'd9, 6'd10, 6'd11, 6'h2c};

    initial begin
        idle('0);
        raddrA = '0; raddrB = '0; raddrC = '0;
        repeat (2) @(negedge clk);
        #3;
        checkOutput("reset_we",    32'(weB),    0);
        checkOutput("reset_waddr", 32'(waddrB), 0);
        checkOutput("reset_wdata", wdataB,      0);
        @(negedge clk) rst_n = 1'b1;

        // Single LSU result to x5.
        @(negedge clk);
        applyStimulus(1, 6'd5, 32'hDEADBEEF, 0, '0, '0, 0, '0, '0, 0, '0);
        #3 checkOutput("x5_lsu_ready", 32'(lsuReady), 1);
        @(negedge clk) idle('0);
        #3;
        checkOutput("x5_we",    32'(weB),    1);
        checkOutput("x5_waddr", 32'(waddrB), 5);
        checkOutput("x5_wdata", wdataB,      32'hDEADBEEF);
        @(negedge clk);
        #3 checkOutput("x5_we_drop", 32'(weB), 0);

        // All three sources valid: grants rotate starting after the LSU winner.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            applyStimulus(1, 6'd1, DW'(k), 1, 6'd2, DW'(k + 100), 1, 6'd33, DW'(k + 200), 0, '0);
            #3;
            checkOutput("rotate_grant", 32'({fpuReady, mdReady, lsuReady}), 32'(rotExp[k]));
            rotCnt[0] += int'(lsuReady);
            rotCnt[1] += int'(mdReady);
            rotCnt[2] += int'(fpuReady);
        end
        checkOutput("rotate_lsu_cnt", rotCnt[0], 2);
        checkOutput("rotate_md_cnt",  rotCnt[1], 2);
        checkOutput("rotate_fpu_cnt", rotCnt[2], 2);

        // FP destination f3 stays busy until its write cycle, clear the cycle after.
        @(negedge clk) applyStimulus(0, '0, '0, 0, '0, '0, 0, '0, '0, 1, 6'h23);
        @(negedge clk) begin idle(6'h23); raddrB = 6'h23; end
        #3;
        checkOutput("f3_busy_b", 32'(busyB),   1);
        checkOutput("f3_waw",    32'(wawBusy), 1);
        @(negedge clk) applyStimulus(0, '0, '0, 0, '0, '0, 1, 6'h23, 32'h3F800000, 0, 6'h23);
        #3;
        checkOutput("f3_fpu_ready", 32'(fpuReady), 1);
        checkOutput("f3_busy_hold", 32'(busyB),    1);
        @(negedge clk) idle(6'h23);
        #3;
        checkOutput("f3_we",         32'(weB),    1);
        checkOutput("f3_waddr",      32'(waddrB), 32'h23);
        checkOutput("f3_busy_write", 32'(busyB),  1);
        @(negedge clk);
        #3;
        checkOutput("f3_busy_clear", 32'(busyB),   0);
        checkOutput("f3_waw_clear",  32'(wawBusy), 0);

        // Re-issue to x7 on the edge its previous write retires: the set must win.
        @(negedge clk) applyStimulus(0, '0, '0, 0, '0, '0, 0, '0, '0, 1, 6'd7);
        @(negedge clk) applyStimulus(0, '0, '0, 1, 6'd7, 32'h77, 0, '0, '0, 0, 6'd7);
        @(negedge clk) applyStimulus(0, '0, '0, 0, '0, '0, 0, '0, '0, 1, 6'd7);
        #3;
        checkOutput("x7_we",    32'(weB),    1);
        checkOutput("x7_waddr", 32'(waddrB), 7);
        @(negedge clk) begin idle('0); raddrA = 6'd7; end
        #3 checkOutput("x7_set_wins", 32'(busyA), 1);

        // Result to x0 is accepted but never written.
        @(negedge clk) begin
            applyStimulus(0, '0, '0, 1, 6'd0, 32'h123, 0, '0, '0, 0, '0);
            raddrC = '0;
        end
        #3;
        checkOutput("x0_md_ready", 32'(mdReady), 1);
        checkOutput("x0_busy_c",   32'(busyC),   0);
        @(negedge clk) idle('0);
        #3 checkOutput("x0_no_we", 32'(weB), 0);

        // Randomized traffic honouring hold-until-accepted and the issue contract.
        curV = '0;
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                if (curV[s] && mLastGnt[s]) curV[s] = 1'b0;
                if (!curV[s] && $urandom_range(0, 1) == 1) begin
                    curV[s] = 1'b1;
                    curA[s] = randAddr();
                    curD[s] = $urandom;
                end
            end
            rIv = ($urandom_range(0, 2) == 0);
            rIa = randAddr();
            if (rIv && mPend[rIa] && !(mWe && mAddr == rIa)) rIv = 1'b0;
            applyStimulus(curV[0], curA[0], curD[0], curV[1], curA[1], curD[1],
                          curV[2], curA[2], curD[2], rIv, rIa);
            raddrA = randAddr();
            raddrB = randAddr();
            raddrC = randAddr();
        end

        // Reset while a write is in flight and four registers are busy.
        @(negedge clk) begin idle('0); rst_n = 1'b0; end
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk) applyStimulus(0, '0, '0, 0, '0, '0, 0, '0, '0, 1, busyRegs[k]);
        end
        @(negedge clk) applyStimulus(1, 6'd12, 32'hCAFE, 0, '0, '0, 0, '0, '0, 0, 6'h2c);
        @(negedge clk) begin
            idle(6'h2c);
            raddrA = 6'd9; raddrB = 6'd10; raddrC = 6'd11;
        end
        #3;
        checkOutput("rst_pre_we",     32'(weB),     1);
        checkOutput("rst_pre_busy_a", 32'(busyA),   1);
        checkOutput("rst_pre_busy_b", 32'(busyB),   1);
        checkOutput("rst_pre_busy_c", 32'(busyC),   1);
        checkOutput("rst_pre_waw",    32'(wawBusy), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async_we",     32'(weB),     0);
        checkOutput("rst_async_busy_a", 32'(busyA),   0);
        checkOutput("rst_async_busy_b", 32'(busyB),   0);
        checkOutput("rst_async_busy_c", 32'(busyC),   0);
        checkOutput("rst_async_waw",    32'(wawBusy), 0);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk)
            applyStimulus(1, 6'd1, 32'h11, 1, 6'd2, 32'h22, 1, 6'd33, 32'h33, 0, '0);
        #3 checkOutput("rst_ptr_lsu", 32'({fpuReady, mdReady, lsuReady}), 32'b001);
        @(negedge clk) idle('0);
        repeat (2) @(negedge clk);
        #3;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
